// File: rtl/uart_frame_dump.sv
// Frame-buffer dump sequencer. It walks a COLS x ROWS word buffer and sends each word
// MSB-first, one byte at a time, to a UART core. An optional two-byte sync header comes first.
module uart_frame_dump #(
  parameter int          COLS           = 40,
  parameter int          ROWS           = 30,
  parameter int          BYTES_PER_WORD = 4,
  parameter int          HOLDOFF_BITS   = 13,
  parameter int          SYNC_EN        = 1,
  parameter logic [7:0]  SYNC0          = 8'hA5,
  parameter logic [7:0]  SYNC1          = 8'h5A,
  localparam int         XW             = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int         YW             = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          continuous_i,
  output logic [XW-1:0]                 read_x,
  output logic [YW-1:0]                 read_y,
  input  logic [8*BYTES_PER_WORD-1:0]   read_q,
  input  logic                          uart_busy,
  output logic                          uart_wr_o,
  output logic [7:0]                    uart_dat_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [15:0]                   frame_count_o
);

  localparam int ZW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int WW = 8 * BYTES_PER_WORD;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [2:0]    S_FIRST = (SYNC_EN != 0) ? S_HDR : S_FETCH;
  localparam logic [XW-1:0] X_LAST  = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(ROWS - 1);
  localparam logic [ZW-1:0] Z_LAST  = ZW'(BYTES_PER_WORD - 1);

  logic [2:0]              r_state;
  logic [XW-1:0]           r_x;
  logic [YW-1:0]           r_y;
  logic [ZW-1:0]           r_z;
  logic                    r_hdrSel;
  logic [WW-1:0]           r_word;
  logic [HOLDOFF_BITS-1:0] r_hold;
  logic                    r_wr;
  logic [7:0]              r_dat;
  logic                    r_done;
  logic [15:0]             r_count;

  logic                    w_canSend;
  logic [7:0]              w_byte;

  assign w_canSend = (&r_hold) && !uart_busy && !r_wr;

  // Byte z of the latched word, counted from the most significant end.
  always_comb begin
    w_byte = 8'h00;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      if (r_z == ZW'(i)) w_byte = r_word[8*(BYTES_PER_WORD-1-i) +: 8];
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_hdrSel <= 1'b0;
      r_word   <= '0;
      r_hold   <= '0;
      r_wr     <= 1'b0;
      r_dat    <= 8'h00;
      r_done   <= 1'b0;
      r_count  <= 16'd0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      // The strobe cycle also restarts the gap, so an idle UART still gets a full holdoff.
      if (uart_busy || r_wr)
        r_hold <= '0;
      else if (!(&r_hold))
        r_hold <= r_hold + 1'b1;

      if (abort_i && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_x      <= '0;
              r_y      <= '0;
              r_z      <= '0;
              r_hdrSel <= 1'b0;
              r_state  <= S_FIRST;
            end
          end
          S_HDR: begin
            if (w_canSend) begin
              r_wr     <= 1'b1;
              r_dat    <= r_hdrSel ? SYNC1 : SYNC0;
              r_hdrSel <= 1'b1;
              if (r_hdrSel) r_state <= S_FETCH;
            end
          end
          S_FETCH: r_state <= S_LATCH;
          S_LATCH: begin
            r_word  <= read_q;
            r_state <= S_SEND;
          end
          S_SEND: begin
            if (w_canSend) begin
              r_wr  <= 1'b1;
              r_dat <= w_byte;
              if (r_z == Z_LAST) begin
                r_z     <= '0;
                r_state <= S_FETCH;
                if (r_x == X_LAST) begin
                  r_x <= '0;
                  if (r_y == Y_LAST) begin
                    r_y     <= '0;
                    r_state <= S_DONE;
                  end else begin
                    r_y <= r_y + 1'b1;
                  end
                end else begin
                  r_x <= r_x + 1'b1;
                end
              end else begin
                r_z <= r_z + 1'b1;
              end
            end
          end
          // Runs during the final strobe cycle, so done_o lands one cycle after it.
          S_DONE: begin
            r_done  <= 1'b1;
            r_count <= r_count + 16'd1;
            if (continuous_i) begin
              r_x      <= '0;
              r_y      <= '0;
              r_z      <= '0;
              r_hdrSel <= 1'b0;
              r_state  <= S_FIRST;
            end else begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign read_x        = r_x;
  assign read_y        = r_y;
  assign uart_wr_o     = r_wr;
  assign uart_dat_o    = r_dat;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = r_done;
  assign frame_count_o = r_count;

endmodule
